// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, types and constants for the FIR tap sequencer
package fir_pkg;
   localparam int TAPS   = 64;
   localparam int TAP_AW = $clog2(TAPS);
   localparam int DW     = 16;
   localparam int CW     = 16;

   localparam logic [TAP_AW-1:0] TAP_LAST = TAP_AW'(TAPS - 1);

   typedef logic signed [DW-1:0] sample_t;
   typedef logic signed [CW-1:0] coef_t;
endpackage

// File: rtl/fir_tap_ram.sv
// rtl/fir_tap_ram.sv - 2**AW x W array, synchronous write, registered read-before-write
module fir_tap_ram #(
   parameter int W         = 16,
   parameter int AW        = 6,
   parameter bit RST_CLEAR = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [0:(1<<AW)-1];

   generate
      if (RST_CLEAR) begin : g_clr
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
            end else if (we) begin
               mem[waddr] <= wdata;
            end
         end
      end else begin : g_noclr
         always_ff @(posedge clk) begin
            if (we) mem[waddr] <= wdata;
         end
      end
   endgenerate

   // Same-address read during a write returns the old contents.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rdata <= '0;
      else        rdata <= mem[raddr];
   end
endmodule

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - streams (x[n-k], coef[k]) pairs to the MAC, one per cycle
// Optional repeat counter enabled by FIR_SEQ_REPEAT_CNT_EN.
module fir_tap_sequencer
   import fir_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  sample_t           din,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic              coef_we,
   input  logic [TAP_AW-1:0] coef_addr,
   input  coef_t             coef_wdata,
   output sample_t           x_out,
   output coef_t             coef_out,
   output logic [TAP_AW-1:0] tap_out,
   output logic              frame_new,
   output logic              repeat_pulse
`ifdef FIR_SEQ_REPEAT_CNT_EN
   ,
   input  logic              repeat_clr,
   output logic [7:0]        repeat_cnt
`endif
);
   logic [TAP_AW-1:0] rd_cnt;
   logic [TAP_AW-1:0] head;
   sample_t           hold;
   logic              hold_full;
   logic              boundary;
   logic              transfer;
   logic              commit;

   assign boundary  = (rd_cnt == TAP_LAST);
   assign din_ready = !hold_full || boundary;
   assign transfer  = din_valid && din_ready;
   assign commit    = boundary && hold_full;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_cnt       <= TAP_AW'(1);
         head         <= '0;
         hold         <= '0;
         hold_full    <= 1'b0;
         tap_out      <= '0;
         frame_new    <= 1'b0;
         repeat_pulse <= 1'b0;
      end else begin
         rd_cnt       <= rd_cnt + 1'b1;
         tap_out      <= rd_cnt;
         repeat_pulse <= boundary && !hold_full;
         if (commit) head <= head + 1'b1;
         if (transfer) begin
            hold      <= din;
            hold_full <= 1'b1;
         end else if (commit) begin
            hold_full <= 1'b0;
         end
         // repeat_pulse is high exactly when the previous boundary committed nothing.
         if (rd_cnt == '0) frame_new <= !repeat_pulse;
      end
   end

`ifdef FIR_SEQ_REPEAT_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                      repeat_cnt <= '0;
      else if (repeat_clr)                             repeat_cnt <= '0;
      else if (boundary && !hold_full && repeat_cnt != 8'hFF) repeat_cnt <= repeat_cnt + 1'b1;
   end
`endif

   fir_tap_ram #(.W(DW), .AW(TAP_AW), .RST_CLEAR(1'b1)) u_delay_line (
      .clk   (clk),
      .reset (reset),
      .we    (commit),
      .waddr (head + 1'b1),
      .wdata (hold),
      .raddr (head - rd_cnt),
      .rdata (x_out)
   );

   fir_tap_ram #(.W(CW), .AW(TAP_AW), .RST_CLEAR(1'b0)) u_coef_ram (
      .clk   (clk),
      .reset (reset),
      .we    (coef_we),
      .waddr (coef_addr),
      .wdata (coef_wdata),
      .raddr (rd_cnt),
      .rdata (coef_out)
   );
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb/tb_fir_tap_sequencer.sv - randomized self-checking bench for fir_tap_sequencer
module tb_fir_tap_sequencer;
   import fir_pkg::*;

   logic        clk;
   logic        reset;
   sample_t     din;
   logic        din_valid;
   logic        din_ready;
   logic        coef_we;
   logic [5:0]  coef_addr;
   coef_t       coef_wdata;
   sample_t     x_out;
   coef_t       coef_out;
   logic [5:0]  tap_out;
   logic        frame_new;
   logic        repeat_pulse;
`ifdef FIR_SEQ_REPEAT_CNT_EN
   logic        repeat_clr;
   logic [7:0]  repeat_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   fir_tap_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .din          (din),
      .din_valid    (din_valid),
      .din_ready    (din_ready),
      .coef_we      (coef_we),
      .coef_addr    (coef_addr),
      .coef_wdata   (coef_wdata),
      .x_out        (x_out),
      .coef_out     (coef_out),
      .tap_out      (tap_out),
      .frame_new    (frame_new),
      .repeat_pulse (repeat_pulse)
`ifdef FIR_SEQ_REPEAT_CNT_EN
      ,
      .repeat_clr   (repeat_clr),
      .repeat_cnt   (repeat_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: history as a newest-first queue, frame snapshot taken at tap 0.
   int          m_tap;
   bit          m_full;
   logic [15:0] m_pend;
   bit          m_committed;
   logic [15:0] hist[$];
   logic [15:0] snap[$];
   logic [15:0] m_cram[64];
   bit          m_cknown[64];
   int          m_cnt;
   logic [15:0] exp_x;
   logic [15:0] exp_coef;
   bit          exp_coef_known;
   logic [5:0]  exp_tap;
   bit          exp_fn;
   bit          exp_rep;

   function automatic bit exp_ready();
      return !m_full || (m_tap == 62);
   endfunction

   task automatic model_reset();
      m_tap = 0; m_full = 0; m_pend = 0; m_committed = 0; m_cnt = 0;
      hist.delete(); snap.delete();
      exp_x = 0; exp_coef = 0; exp_coef_known = 1; exp_tap = 0; exp_fn = 0; exp_rep = 0;
   endtask

   task automatic model_edge();
      int nt;
      bit xfer, cmt, old_full;
      nt       = (m_tap + 1) % 64;
      xfer     = din_valid && exp_ready();
      old_full = m_full;
      cmt      = (nt == 63) && m_full;
      exp_coef       = m_cram[nt];
      exp_coef_known = m_cknown[nt];
      if (nt == 0) begin
         exp_fn = m_committed;
         snap   = hist;
      end
      exp_x = (nt < snap.size()) ? snap[nt] : 16'h0;
      exp_rep = (nt == 63) && !old_full;
      if (nt == 63) m_committed = cmt;
      if (cmt) begin
         hist.push_front(m_pend);
         if (hist.size() > 64) void'(hist.pop_back());
      end
`ifdef FIR_SEQ_REPEAT_CNT_EN
      if (repeat_clr) m_cnt = 0;
      else if (nt == 63 && !old_full && m_cnt < 255) m_cnt++;
`endif
      if (xfer) begin
         m_pend = din;
         m_full = 1;
      end else if (cmt) begin
         m_full = 0;
      end
      if (coef_we) begin
         m_cram[coef_addr]   = coef_wdata;
         m_cknown[coef_addr] = 1;
      end
      m_tap   = nt;
      exp_tap = 6'(nt);
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (tap_out !== 6'd0 || x_out !== 16'sd0 || coef_out !== 16'sd0 ||
             frame_new !== 1'b0 || repeat_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs tap=%0d x=%h coef=%h fn=%b rep=%b required all 0",
                     tap_out, x_out, coef_out, frame_new, repeat_pulse);
         end
      end
      reset = 1'b1;
      checks++;
      if (tap_out !== 6'd0 || x_out !== 16'sd0) begin
         failures++;
         $display("FAIL release_first tap=%0d x=%h required 0/0", tap_out, x_out);
      end
   endtask

   task automatic test_idle_frames();
      int pulses = 0;
      for (int c = 0; c < 192; c++) begin
         coef_we    = (c < 64);
         coef_addr  = 6'(c);
         coef_wdata = 16'(c + 1);
         tick();
         checks++;
         if (tap_out !== exp_tap || x_out !== 16'sd0 || repeat_pulse !== exp_rep) begin
            failures++;
            $display("FAIL idle tap=%0d/%0d x=%h/0 rep=%b/%b", tap_out, exp_tap, x_out, repeat_pulse, exp_rep);
         end
         if (repeat_pulse === 1'b1) pulses++;
         if (c >= 64) begin
            checks++;
            if (coef_out !== 16'(tap_out + 1)) begin
               failures++;
               $display("FAIL idle_coef tap=%0d coef=%h required %h", tap_out, coef_out, 16'(tap_out + 1));
            end
         end
      end
      coef_we = 0;
      checks++;
      if (pulses != 3) begin
         failures++;
         $display("FAIL idle_pulse_count got %0d required 3", pulses);
      end
   endtask

   task automatic test_impulse();
      int hits = 0;
      for (int i = 0; i < 64 && tap_out != 6'd20; i++) tick();
      din = 16'sh7FFF; din_valid = 1;
      tick();
      din = 16'sd0;
      for (int c = 0; c < 67 * 64; c++) begin
         tick();
         checks++;
         if (x_out !== exp_x || frame_new !== exp_fn) begin
            failures++;
            $display("FAIL impulse tap=%0d x=%h/%h fn=%b/%b", tap_out, x_out, exp_x, frame_new, exp_fn);
         end
         if (x_out === 16'sh7FFF) hits++;
      end
      din_valid = 0;
      checks++;
      if (hits != 64) begin
         failures++;
         $display("FAIL impulse_hits got %0d required 64", hits);
      end
   endtask

   task automatic test_ramp();
      bit xfer;
      for (int k = 0; k < 64; k++) begin
         coef_we = 1; coef_addr = 6'(k); coef_wdata = 16'sd1;
         tick();
      end
      coef_we = 0;
      din = 16'sd1; din_valid = 1;
      for (int c = 0; c < 12 * 64; c++) begin
         xfer = din_valid && exp_ready();
         tick();
         if (xfer) din = din + 16'sd1;
         checks++;
         if (x_out !== exp_x || coef_out !== 16'sd1 || tap_out !== exp_tap) begin
            failures++;
            $display("FAIL ramp tap=%0d x=%h/%h coef=%h/0001", tap_out, x_out, exp_x, coef_out);
         end
      end
      din_valid = 0;
   endtask

   task automatic test_back_to_back();
      bit xfer;
      int accepted = 0;
      din = 16'sh0100; din_valid = 1;
      for (int c = 0; c < 8 * 64; c++) begin
         checks++;
         if (din_ready !== exp_ready()) begin
            failures++;
            $display("FAIL b2b_ready tap=%0d ready=%b required %b", tap_out, din_ready, exp_ready());
         end
         xfer = din_valid && exp_ready();
         tick();
         if (xfer) begin
            accepted++;
            din = din + 16'sd1;
         end
         checks++;
         if (x_out !== exp_x || frame_new !== exp_fn || repeat_pulse !== exp_rep) begin
            failures++;
            $display("FAIL b2b tap=%0d x=%h/%h fn=%b/%b rep=%b/%b", tap_out, x_out, exp_x,
                     frame_new, exp_fn, repeat_pulse, exp_rep);
         end
      end
      din_valid = 0;
      checks++;
      if (accepted < 8 || accepted > 9) begin
         failures++;
         $display("FAIL b2b_accept_count got %0d required 8..9", accepted);
      end
   endtask

   task automatic test_coef_same_cycle();
      for (int i = 0; i < 64 && tap_out != 6'd4; i++) tick();
      coef_we = 1; coef_addr = 6'd5; coef_wdata = 16'sh1234;
      tick();
      coef_we = 0;
      checks++;
      if (tap_out !== 6'd5 || coef_out !== 16'sd1) begin
         failures++;
         $display("FAIL coef_same_cycle tap=%0d coef=%h required tap 5 coef 0001", tap_out, coef_out);
      end
      for (int i = 0; i < 64; i++) tick();
      checks++;
      if (tap_out !== 6'd5 || coef_out !== 16'sh1234) begin
         failures++;
         $display("FAIL coef_next_frame tap=%0d coef=%h required tap 5 coef 1234", tap_out, coef_out);
      end
   endtask

   task automatic test_reset_midframe();
      for (int i = 0; i < 130 && tap_out != 6'd10; i++) tick();
      din = 16'sh5555; din_valid = 1;
      tick();
      din_valid = 0;
      for (int i = 0; i < 64 && tap_out != 6'd30; i++) tick();
      checks++;
      if (din_ready !== 1'b0 || tap_out !== 6'd30) begin
         failures++;
         $display("FAIL midreset_setup tap=%0d ready=%b required tap 30 ready 0", tap_out, din_ready);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (tap_out !== 6'd0 || x_out !== 16'sd0 || coef_out !== 16'sd0 ||
          frame_new !== 1'b0 || repeat_pulse !== 1'b0) begin
         failures++;
         $display("FAIL midreset_async tap=%0d x=%h coef=%h fn=%b rep=%b required all 0",
                  tap_out, x_out, coef_out, frame_new, repeat_pulse);
      end
`ifdef FIR_SEQ_REPEAT_CNT_EN
      checks++;
      if (repeat_cnt !== 8'd0) begin
         failures++;
         $display("FAIL midreset_cnt got %0d required 0", repeat_cnt);
      end
`endif
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 128; c++) begin
         tick();
         checks++;
         if (tap_out !== exp_tap || x_out !== 16'sd0 || frame_new !== 1'b0 || repeat_pulse !== exp_rep) begin
            failures++;
            $display("FAIL midreset_after tap=%0d/%0d x=%h/0 fn=%b/0 rep=%b/%b",
                     tap_out, exp_tap, x_out, frame_new, repeat_pulse, exp_rep);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 30 * 64; c++) begin
         din        = 16'($urandom);
         din_valid  = ($urandom_range(0, 2) == 0);
         coef_we    = ($urandom_range(0, 5) == 0);
         coef_addr  = 6'($urandom_range(0, 63));
         coef_wdata = 16'($urandom);
`ifdef FIR_SEQ_REPEAT_CNT_EN
         repeat_clr = ($urandom_range(0, 200) == 0);
`endif
         checks++;
         if (din_ready !== exp_ready()) begin
            failures++;
            $display("FAIL rand_ready tap=%0d ready=%b required %b", tap_out, din_ready, exp_ready());
         end
         tick();
         checks++;
         if (tap_out !== exp_tap || x_out !== exp_x || frame_new !== exp_fn ||
             repeat_pulse !== exp_rep || (exp_coef_known && coef_out !== exp_coef)) begin
            failures++;
            $display("FAIL rand tap=%0d/%0d x=%h/%h coef=%h/%h fn=%b/%b rep=%b/%b", tap_out, exp_tap,
                     x_out, exp_x, coef_out, exp_coef, frame_new, exp_fn, repeat_pulse, exp_rep);
         end
`ifdef FIR_SEQ_REPEAT_CNT_EN
         checks++;
         if (repeat_cnt !== 8'(m_cnt)) begin
            failures++;
            $display("FAIL rand_cnt got %0d required %0d", repeat_cnt, m_cnt);
         end
`endif
      end
      din_valid = 0; coef_we = 0;
`ifdef FIR_SEQ_REPEAT_CNT_EN
      repeat_clr = 0;
`endif
   endtask

   initial begin
      clk = 0; reset = 0;
      din = 0; din_valid = 0;
      coef_we = 0; coef_addr = 0; coef_wdata = 0;
`ifdef FIR_SEQ_REPEAT_CNT_EN
      repeat_clr = 0;
`endif
      for (int i = 0; i < 64; i++) begin
         m_cram[i] = 16'h0; m_cknown[i] = 0;
      end
      model_reset();
      test_reset();
      test_idle_frames();
      test_impulse();
      test_ramp();
      test_back_to_back();
      test_coef_same_cycle();
      test_reset_midframe();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Upstream feeder for the FIR MAC/FP-conversion stage, running on the same 640 kHz core clock.
- Holds a 64-entry circular sample delay line and a 64-entry coefficient RAM.
- Streams one (sample, coefficient) pair per cycle: x[n-k] with coef[k], for k = 0..63.
- Each 64-cycle frame is locked to the MAC stage's free-running tap counter. New samples arrive via a valid/ready handshake at 10 kHz (one per frame).

Parameters:
- TAPS, 64, number of taps; must be a power of two; addresses are log2(TAPS) bits.
- DW, 16, sample width, signed two's complement.
- CW, 16, coefficient width, signed two's complement.

Ports:
- clk  in  1  core clock (640 kHz).
- reset  in  1  asynchronous, active-low reset.
- din  in  DW  input sample.
- din_valid  in  1  din is valid.
- din_ready  out  1  sequencer can accept din this cycle.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  6  coefficient index k.
- coef_wdata  in  CW  coefficient value.
- x_out  out  DW  delayed sample x[n-k]; drives MAC x_in.
- coef_out  out  CW  coef[k]; drives MAC cmem_coef.
- tap_out  out  6  k of the current pair; equals the MAC's tap index.
- frame_new  out  1  high for all 64 cycles of a frame built on a newly committed sample.
- repeat_pulse  out  1  one-cycle pulse when a frame boundary passes with no pending sample.

Behaviour:
- Reset (async, low): all outputs are 0. rd_cnt=1, head=0, hold_full=0, delay line cleared to 0. Coefficient RAM is not reset.
  - Outputs therefore present tap 0 (value 0) in the first cycle after release. This aligns with the MAC counter, which also resets to 0.
- rd_cnt (6 b) free-runs and wraps 63->0. It always leads tap_out by one.
- Output registers load on every clock edge:
  - tap_out<=rd_cnt
  - x_out<=dl[(head-rd_cnt) mod 64]
  - coef_out<=cram[rd_cnt]
- Latency: registered outputs, one cycle from address to data. No stalls. Frames are never interrupted.
- Input handshake:
  - One-entry hold register.
  - din_ready = !hold_full || (rd_cnt==63).
  - A transfer occurs when din_valid && din_ready; din is captured into hold and hold_full is set.
- Commit (edge where rd_cnt==63 and hold_full):
  - head<=head+1; dl[head+1]<=hold.
  - hold_full clears, unless a new transfer occurs in the same cycle, in which case it stays set with the new value.
  - The next frame's tap 0 presents the new sample.
- Edge where rd_cnt==63 and !hold_full:
  - head is unchanged; the next frame recomputes the previous history.
  - repeat_pulse=1 for one cycle; frame_new=0 for that frame.
- frame_new updates at the edge where tap_out becomes 0, and holds for 64 cycles.
- Delay-line wrap: head and the (head-k) index arithmetic are modulo 64. After 64 commits, the oldest sample is overwritten.
- Coefficient write:
  - cram[coef_addr]<=coef_wdata, accepted in any cycle.
  - A same-cycle read of the same address returns the old value.
  - A write mid-frame to an index already read in that frame takes effect from the next frame.
- Only one state register is needed (rd_cnt). There is no idle state; streaming is continuous from reset release.
- Reset asserted mid-frame: everything returns to the reset values above, and the pending sample is lost. Realignment with the MAC is automatic because both counters reset together.

Optional Feature:
- Macro: FIR_SEQ_REPEAT_CNT_EN.
- Defined:
  - Adds output repeat_cnt [7:0]: a saturating count of repeat_pulse events (holds at 255).
  - Reset 0; cleared by input repeat_clr (1 b, synchronous, with priority over increment).
- Undefined: no extra ports or logic.

Decomposition:
- Shared package fir_pkg:
  - TAPS=64, TAP_AW=6, DW=16, CW=16.
  - Signed sample_t/coef_t typedefs.
  - TAP_LAST=63 constant.
- One natural sub-module, fir_tap_ram: a 64xW synchronous-write / registered-read array with reset clear. It is instantiated twice (delay line, coefficients); the coefficient instance has its reset clear disabled by a parameter.

Test Plan:
- Reset release, no input, coefs loaded 1..64 -> x_out=0 for all taps. tap_out follows 0..63 in step with the MAC counter. repeat_pulse fires every 64 cycles.
- Impulse: din=16'h7FFF accepted mid-frame, then zeros each frame -> in frame j, x_out=7FFF only at tap_out=j (j=0..63). Frame 64 is all zero.
- Coefs all 16'h0001, ramp samples 1,2,3... one per frame -> frame n presents x_out = n, n-1, ..., 1, then 0 for k>=n.
- Back-to-back din_valid held high -> second sample is accepted only at rd_cnt==63 and committed next frame. din_ready is low otherwise. No sample is lost or duplicated.
- coef_we to addr 5 in the same cycle as its read -> coef_out shows the old value. The next frame shows the new value.
- Reset pulse at tap 30 with hold_full=1 -> outputs go 0 asynchronously. After release, tap_out restarts at 0 and the pending sample is dropped. With the macro defined, repeat_cnt=0.
